// File: rtl/romulus_config_pkg.sv
`default_nettype none
// ============================================================================
// Module   : romulus_config_pkg
// Purpose  : Shared configuration, state encoding and constants for the
//            Romulus TBC control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package romulus_config_pkg;

  localparam int BUSW         = 32;
  localparam int RNDS_PER_CLK = 4;
  localparam int NUMRNDS      = 40;
  localparam int CNTW         = 6;

  localparam int CONSTW     = CNTW * RNDS_PER_CLK;
  localparam int KEY_BEATS  = 128 / BUSW;
  localparam int BEAT_W     = (KEY_BEATS > 1) ? $clog2(KEY_BEATS) : 1;
  localparam int TBC_CYCLES = NUMRNDS / RNDS_PER_CLK;
  localparam int RND_W      = (TBC_CYCLES > 1) ? $clog2(TBC_CYCLES) : 1;

  localparam logic [CNTW-1:0] c_RC_INIT = CNTW'(6'h00);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_TBC  = 2'd2,
    ST_CORR = 2'd3
  } seq_state_t;

  function automatic logic state_busy(input seq_state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/romulus_tbc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : romulus_tbc_sequencer_if
// Purpose  : Request/handshake and datapath-control bundle between the mode
//            FSM (master) and the TBC sequencer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface romulus_tbc_sequencer_if;
  import romulus_config_pkg::*;

  logic              start;
  logic              key_start;
  logic              cnt_inc;
  logic              key_valid;
  logic              key_ready;
  logic              ready;
  logic              busy;
  logic              done;
  logic [CONSTW-1:0] constant;
  logic              senc;
  logic              sen;
  logic              xenc;
  logic              xen;
  logic              xrst;
  logic              yenc;
  logic              yen;
  logic              zenc;
  logic              zen;
  logic              correct_cnt;

  modport master (
    output start, key_start, cnt_inc, key_valid,
    input  key_ready, ready, busy, done, constant,
    input  senc, sen, xenc, xen, xrst, yenc, yen, zenc, zen, correct_cnt
  );

  modport slave (
    input  start, key_start, cnt_inc, key_valid,
    output key_ready, ready, busy, done, constant,
    output senc, sen, xenc, xen, xrst, yenc, yen, zenc, zen, correct_cnt
  );

endinterface
`default_nettype wire

// File: rtl/skinny_rc_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : skinny_rc_lfsr
// Purpose  : Combinational unroll of N_STEPS SKINNY round-constant LFSR steps.
// Revision : 1.0 - initial release
// ============================================================================
module skinny_rc_lfsr #(
  parameter int N_STEPS = 4,
  parameter int RC_W    = 6
) (
  input  wire logic [RC_W-1:0]         i_rc,
  output logic      [RC_W*N_STEPS-1:0] o_constant,
  output logic      [RC_W-1:0]         o_rc_next
);

  // Slice i holds the state after i+1 steps; the final state feeds the register.
  always_comb begin
    logic [RC_W-1:0] v_rc;
    v_rc       = i_rc;
    o_constant = '0;
    for (int i = 0; i < N_STEPS; i++) begin
      v_rc = {v_rc[RC_W-2:0], ~(v_rc[RC_W-1] ^ v_rc[RC_W-2])};
      o_constant[RC_W*i +: RC_W] = v_rc;
    end
    o_rc_next = v_rc;
  end

endmodule
`default_nettype wire

// File: rtl/romulus_tbc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : romulus_tbc_sequencer
// Purpose  : Key load, unrolled round loop and tweakey-correction sequencing
//            for one Romulus tweakable-block-cipher invocation.
// Revision : 1.0 - initial release
// ============================================================================
module romulus_tbc_sequencer
  import romulus_config_pkg::*;
(
  input wire logic               clk,
  input wire logic               rst,
  romulus_tbc_sequencer_if.slave bus
);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [RND_W-1:0]  r_rnd_cnt;
  logic [CNTW-1:0]   r_rc;
  logic [CNTW-1:0]   w_rc_nxt;
  logic [CONSTW-1:0] w_rc_bus;
  logic              r_done;
  logic              w_last_beat;
  logic              w_last_rnd;

  logic w_key_ready, w_xrst, w_senc, w_sen, w_xenc, w_xen;
  logic w_yenc, w_yen, w_zenc, w_zen, w_correct_cnt;

  skinny_rc_lfsr #(
    .N_STEPS (RNDS_PER_CLK),
    .RC_W    (CNTW)
  ) u_rc_lfsr (
    .i_rc       (r_rc),
    .o_constant (w_rc_bus),
    .o_rc_next  (w_rc_nxt)
  );

  assign w_last_beat = bus.key_valid && (r_beat_cnt == BEAT_W'(KEY_BEATS - 1));
  assign w_last_rnd  = (r_rnd_cnt == RND_W'(TBC_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters and LFSR are re-armed every IDLE cycle so a new job starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_rnd_cnt  <= '0;
      r_rc       <= c_RC_INIT;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == ST_CORR);
      case (r_state)
        ST_IDLE: begin
          r_beat_cnt <= '0;
          r_rnd_cnt  <= '0;
          r_rc       <= c_RC_INIT;
        end
        ST_KEY: begin
          if (bus.key_valid) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
          end
        end
        ST_TBC: begin
          r_rnd_cnt <= r_rnd_cnt + RND_W'(1);
          r_rc      <= w_rc_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_key_ready   = 1'b0;
    w_xrst        = 1'b0;
    w_senc        = 1'b0;
    w_sen         = 1'b0;
    w_xenc        = 1'b0;
    w_xen         = 1'b0;
    w_yenc        = 1'b0;
    w_yen         = 1'b0;
    w_zenc        = 1'b0;
    w_zen         = 1'b0;
    w_correct_cnt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Fixed priority; losing requests are simply dropped.
        if (bus.key_start) begin
          w_state_nxt = ST_KEY;
        end else if (bus.cnt_inc) begin
          w_zen         = 1'b1;
          w_correct_cnt = 1'b1;
        end else if (bus.start) begin
          w_state_nxt = ST_TBC;
        end
      end
      ST_KEY: begin
        w_key_ready = 1'b1;
        w_xrst      = bus.key_valid;
        if (w_last_beat) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_TBC: begin
        w_senc = 1'b1;
        w_sen  = 1'b1;
        w_xenc = 1'b1;
        w_xen  = 1'b1;
        w_yenc = 1'b1;
        w_yen  = 1'b1;
        w_zenc = 1'b1;
        w_zen  = 1'b1;
        if (w_last_rnd) begin
          w_state_nxt = ST_CORR;
        end
      end
      ST_CORR: begin
        w_xen       = 1'b1;
        w_yen       = 1'b1;
        w_zen       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.ready       = (r_state == ST_IDLE);
  assign bus.busy        = state_busy(r_state);
  assign bus.done        = r_done;
  assign bus.key_ready   = w_key_ready;
  assign bus.constant    = (r_state == ST_TBC) ? w_rc_bus : '0;
  assign bus.senc        = w_senc;
  assign bus.sen         = w_sen;
  assign bus.xenc        = w_xenc;
  assign bus.xen         = w_xen;
  assign bus.xrst        = w_xrst;
  assign bus.yenc        = w_yenc;
  assign bus.yen         = w_yen;
  assign bus.zenc        = w_zenc;
  assign bus.zen         = w_zen;
  assign bus.correct_cnt = w_correct_cnt;

endmodule
`default_nettype wire

// File: tb/tb_romulus_tbc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_romulus_tbc_sequencer
// Purpose  : Randomized self-checking bench for romulus_tbc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_romulus_tbc_sequencer;
  import romulus_config_pkg::*;

  // Control vector bit positions, as packed by ctl().
  localparam logic [13:0] B_READY = 14'h2000;
  localparam logic [13:0] B_BUSY  = 14'h1000;
  localparam logic [13:0] B_DONE  = 14'h0800;
  localparam logic [13:0] B_KRDY  = 14'h0400;
  localparam logic [13:0] B_SENC  = 14'h0200;
  localparam logic [13:0] B_SEN   = 14'h0100;
  localparam logic [13:0] B_XENC  = 14'h0080;
  localparam logic [13:0] B_XEN   = 14'h0040;
  localparam logic [13:0] B_XRST  = 14'h0020;
  localparam logic [13:0] B_YENC  = 14'h0010;
  localparam logic [13:0] B_YEN   = 14'h0008;
  localparam logic [13:0] B_ZENC  = 14'h0004;
  localparam logic [13:0] B_ZEN   = 14'h0002;
  localparam logic [13:0] B_CC    = 14'h0001;

  localparam logic [13:0] E_IDLE = B_READY;
  localparam logic [13:0] E_INC  = B_READY | B_ZEN | B_CC;
  localparam logic [13:0] E_KEY  = B_BUSY | B_KRDY;
  localparam logic [13:0] E_TBC  = B_BUSY | B_SENC | B_SEN | B_XENC | B_XEN |
                                   B_YENC | B_YEN | B_ZENC | B_ZEN;
  localparam logic [13:0] E_CORR = B_BUSY | B_XEN | B_YEN | B_ZEN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  romulus_tbc_sequencer_if bus();

  romulus_tbc_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [5:0]  rc_seq [0:NUMRNDS];
  logic [23:0] first_c;
  logic [23:0] last_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] ctl();
    return {bus.ready, bus.busy, bus.done, bus.key_ready, bus.senc, bus.sen,
            bus.xenc, bus.xen, bus.xrst, bus.yenc, bus.yen, bus.zenc, bus.zen,
            bus.correct_cnt};
  endfunction

  // Constant bus expected in the k-th TBC cycle (k = 1..TBC_CYCLES).
  function automatic logic [23:0] tbc_const(input int k);
    logic [23:0] c;
    c = '0;
    for (int j = 0; j < RNDS_PER_CLK; j++) begin
      c = c | (24'(rc_seq[RNDS_PER_CLK*(k-1) + j + 1]) << (CNTW*j));
    end
    return c;
  endfunction

  task automatic step(input bit st, input bit ks, input bit ci, input bit kv, input bit r,
                      input logic [13:0] ectl, input logic [23:0] econst, input string tag);
    @(negedge clk);
    bus.start     = st;
    bus.key_start = ks;
    bus.cnt_inc   = ci;
    bus.key_valid = kv;
    rst           = r;
    #1;
    check({tag, "_ctl"}, 32'(ctl()), 32'(ectl));
    check({tag, "_const"}, 32'(bus.constant), 32'(econst));
  endtask

  // Runs the cycles after an accepted start; abort_at>0 asserts rst in that TBC cycle.
  task automatic run_tbc(input int abort_at, input bit chain, output bit aborted);
    aborted = 1'b0;
    for (int k = 1; k <= TBC_CYCLES; k++) begin
      logic r_now;
      r_now = (k == abort_at);
      step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), r_now, E_TBC, tbc_const(k), "tbc");
      if (k == 1)          first_c = bus.constant;
      if (k == TBC_CYCLES) last_c  = bus.constant;
      if (r_now) begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "abort_idle");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "abort_nodone");
        aborted = 1'b1;
        return;
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_CORR, 24'h0, "corr");
    step(chain, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE | B_DONE, 24'h0, "done");
  endtask

  task automatic key_load(input bit st, input bit ci);
    int beats;
    int guard;
    bit kv;
    step(st, 1'b1, ci, 1'b0, 1'b0, E_IDLE, 24'h0, "rkey_req");
    beats = 0;
    guard = 0;
    while (beats < KEY_BEATS) begin
      kv = (guard > 40) ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           kv, 1'b0, E_KEY | (kv ? B_XRST : 14'h0), 24'h0, "rkey_beat");
      beats += int'(kv);
      guard++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "rkey_exit");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit aborted;
    bit chain;
    int xcnt;
    int abort_at;
    bit kv_pat [6];

    rc_seq[0] = 6'h00;
    for (int i = 1; i <= NUMRNDS; i++) begin
      rc_seq[i] = 6'(((rc_seq[i-1] << 1) & 6'h3E) |
                     (~((rc_seq[i-1] >> 5) ^ (rc_seq[i-1] >> 4)) & 6'h01));
    end

    bus.start = 1'b0; bus.key_start = 1'b0; bus.cnt_inc = 1'b0; bus.key_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "reset_idle");
    end

    // Plain cipher invocation
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "start_req");
    run_tbc(0, 1'b0, aborted);
    check("first_const", 32'(first_c), 32'h3C70C1);
    check("last_const", 32'(last_c), 32'h6ADD9B);

    // Key load with stalls
    kv_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    xcnt = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "key_req");
    foreach (kv_pat[i]) begin
      step(1'b0, 1'b0, 1'b0, kv_pat[i], 1'b0, E_KEY | (kv_pat[i] ? B_XRST : 14'h0), 24'h0, "key_beat");
      if (bus.xrst) xcnt++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "key_exit");
    check("xrst_pulses", 32'(xcnt), 32'd4);

    // key_start wins over start
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "prio_req");
    for (int i = 0; i < KEY_BEATS; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_KEY | B_XRST, 24'h0, "prio_key");
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "prio_exit");

    // Back-to-back counter increments
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_INC, 24'h0, "cnt_inc");
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "cnt_idle");

    // Reset in TBC cycle 5, then a fresh start
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "abort_req");
    run_tbc(5, 1'b0, aborted);
    check("abort_seen", 32'(aborted), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "restart_req");
    run_tbc(0, 1'b0, aborted);
    check("restart_first_const", 32'(first_c), 32'h3C70C1);

    // Random operation mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, E_IDLE, 24'h0, "rstart_req");
          abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TBC_CYCLES)) : 0;
          do begin
            chain = 1'($urandom_range(0, 1));
            run_tbc(abort_at, chain, aborted);
            abort_at = 0;
          end while (chain && !aborted);
        end
        1: key_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        2: begin
          for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0, E_INC, 24'h0, "rcnt_inc");
          end
          step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 24'h0, "rcnt_idle");
        end
        default: begin
          for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
            step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, E_IDLE, 24'h0, "ridle");
          end
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
